// File: rtl/rst_seq_ctrl_if.sv
// Control/status bundle between the reset sequencer and its controller:
// soft restart and delay programming in, sequenced resets and status out.
interface rst_seq_ctrl_if #(
  parameter int N_STAGES  = 4,
  parameter int DLY_WIDTH = 16
);
  logic                          rst_req_i;
  logic [N_STAGES*DLY_WIDTH-1:0] dly_i;
  logic [N_STAGES-1:0]           rstn_o;
  logic [2:0]                    stage_o;
  logic                          busy_o;
  logic                          done_o;

  modport master (
    output rst_req_i, dly_i,
    input  rstn_o, stage_o, busy_o, done_o
  );

  modport slave (
    input  rst_req_i, dly_i,
    output rstn_o, stage_o, busy_o, done_o
  );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Reset sequencer: holds all downstream resets for HOLD_CYCLES, then releases
// N_STAGES active-low resets in order, each after its own captured delay.
module rst_seq_ctrl #(
  parameter int N_STAGES    = 4,
  parameter int DLY_WIDTH   = 16,
  parameter int HOLD_CYCLES = 10
) (
  input logic           clk_sys_i,
  input logic           sys_rst_i,
  rst_seq_ctrl_if.slave bus
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int CNT_W  = (DLY_WIDTH > HOLD_W) ? DLY_WIDTH : HOLD_W;
  localparam int IDX_W  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_STAGE = IDX_W'(N_STAGES - 1);

  typedef enum logic [1:0] {
    ST_HOLD,
    ST_RELEASE,
    ST_DONE
  } state_t;

  state_t                                  state_q, state_d;
  logic [CNT_W-1:0]                        cnt_q, cnt_d;
  logic [IDX_W-1:0]                        k_q, k_d;
  logic [N_STAGES-1:0][DLY_WIDTH-1:0]      shadow_q, shadow_d;
  logic [N_STAGES-1:0]                     rstn_q, rstn_d;

  always_ff @(posedge clk_sys_i) begin
    if (sys_rst_i) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      k_q      <= '0;
      shadow_q <= '0;
      rstn_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
      shadow_q <= shadow_d;
      rstn_q   <= rstn_d;
    end
  end

  // A soft request is treated exactly like a system reset, from any state.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    shadow_d = shadow_q;
    rstn_d   = rstn_q;

    if (bus.rst_req_i) begin
      state_d  = ST_HOLD;
      cnt_d    = '0;
      k_d      = '0;
      shadow_d = '0;
      rstn_d   = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          rstn_d = '0;
          if (cnt_q == HOLD_LAST) begin
            cnt_d    = '0;
            k_d      = '0;
            shadow_d = bus.dly_i;
            state_d  = ST_RELEASE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_RELEASE: begin
          if (cnt_q == CNT_W'(shadow_q[k_q])) begin
            rstn_d[k_q] = 1'b1;
            cnt_d       = '0;
            if (k_q == LAST_STAGE) begin
              state_d = ST_DONE;
            end else begin
              k_d = k_q + IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_DONE: begin
        end

        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  assign bus.rstn_o  = rstn_q;
  assign bus.stage_o = 3'(k_q);
  assign bus.done_o  = (state_q == ST_DONE);
  assign bus.busy_o  = (state_q != ST_DONE);

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Bench for rst_seq_ctrl: directed sequences plus randomized restarts and delay
// changes, checked every cycle against a release-time model.
module tb_rst_seq_ctrl;

  localparam int N    = 4;
  localparam int DW   = 16;
  localparam int HOLD = 10;

  logic clk_sys_i;
  logic sys_rst_i;

  rst_seq_ctrl_if #(.N_STAGES(N), .DLY_WIDTH(DW)) bus_if ();

  rst_seq_ctrl #(
    .N_STAGES   (N),
    .DLY_WIDTH  (DW),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clk_sys_i(clk_sys_i),
    .sys_rst_i(sys_rst_i),
    .bus      (bus_if)
  );

  initial clk_sys_i = 1'b0;
  always #5 clk_sys_i = ~clk_sys_i;

  int err_count   = 0;
  int check_count = 0;

  // Model: edges since the last reset/request, plus the delays captured at edge HOLD.
  int          m_edges;
  logic [DW-1:0] m_shadow [N];

  int edge_n;
  int rise_edge [N];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h (edge %0d)", tag, observed, expected, edge_n);
    end
  endtask

  function automatic int releasedCount();
    int t;
    int rel;
    t   = HOLD;
    rel = 0;
    for (int k = 0; k < N; k++) begin
      t = t + int'(m_shadow[k]) + 1;
      if (m_edges >= t) rel++;
      else break;
    end
    return rel;
  endfunction

  task automatic clearRises();
    for (int k = 0; k < N; k++) rise_edge[k] = -1;
  endtask

  // Advance n clock edges, update the model with the inputs seen at each edge,
  // then compare all outputs 1 ns later.
  task automatic applyStimulus(input int n);
    logic [N-1:0] prev;
    int rel;
    for (int i = 0; i < n; i++) begin
      prev = bus_if.rstn_o;
      @(posedge clk_sys_i);
      if (sys_rst_i || bus_if.rst_req_i) begin
        m_edges = 0;
        for (int k = 0; k < N; k++) m_shadow[k] = '0;
      end else begin
        m_edges++;
        if (m_edges == HOLD)
          for (int k = 0; k < N; k++) m_shadow[k] = bus_if.dly_i[k*DW +: DW];
      end
      edge_n++;
      #1;
      for (int k = 0; k < N; k++)
        if (!prev[k] && bus_if.rstn_o[k]) rise_edge[k] = edge_n;
      rel = releasedCount();
      checkOutput("rstn",  32'(bus_if.rstn_o),  32'((1 << rel) - 1));
      checkOutput("stage", 32'(bus_if.stage_o), 32'((rel == N) ? N - 1 : rel));
      checkOutput("done",  32'(bus_if.done_o),  32'(rel == N));
      checkOutput("busy",  32'(bus_if.busy_o),  32'(rel != N));
    end
  endtask

  task automatic startSeq(input logic [N*DW-1:0] dly);
    bus_if.dly_i     = dly;
    bus_if.rst_req_i = 1'b0;
    sys_rst_i        = 1'b1;
    applyStimulus(1);
    sys_rst_i = 1'b0;
    edge_n    = 0;
    clearRises();
  endtask

  task automatic checkRises(input string tag, input int e0, input int e1,
                            input int e2, input int e3);
    checkOutput({tag, "_rise0"}, 32'(rise_edge[0]), 32'(e0));
    checkOutput({tag, "_rise1"}, 32'(rise_edge[1]), 32'(e1));
    checkOutput({tag, "_rise2"}, 32'(rise_edge[2]), 32'(e2));
    checkOutput({tag, "_rise3"}, 32'(rise_edge[3]), 32'(e3));
  endtask

  initial begin
    logic [N*DW-1:0] d;
    m_edges          = 0;
    edge_n           = 0;
    sys_rst_i        = 1'b1;
    bus_if.rst_req_i = 1'b0;
    bus_if.dly_i     = '0;
    for (int k = 0; k < N; k++) m_shadow[k] = '0;
    clearRises();

    applyStimulus(3);
    checkOutput("reset_rstn",  32'(bus_if.rstn_o),  32'h0);
    checkOutput("reset_stage", 32'(bus_if.stage_o), 32'h0);
    checkOutput("reset_busy",  32'(bus_if.busy_o),  32'h1);
    checkOutput("reset_done",  32'(bus_if.done_o),  32'h0);

    // Basic sequence, delays {2,5,3,0} for stages 3..0
    startSeq({16'd2, 16'd5, 16'd3, 16'd0});
    applyStimulus(30);
    checkRises("t1", 11, 15, 21, 24);
    checkOutput("t1_done", 32'(bus_if.done_o), 32'h1);

    // System reset while in DONE
    sys_rst_i = 1'b1;
    applyStimulus(1);
    checkOutput("t5_rstn",  32'(bus_if.rstn_o),  32'h0);
    checkOutput("t5_done",  32'(bus_if.done_o),  32'h0);
    checkOutput("t5_busy",  32'(bus_if.busy_o),  32'h1);
    checkOutput("t5_stage", 32'(bus_if.stage_o), 32'h0);
    sys_rst_i = 1'b0;

    // All-zero delays release on consecutive edges
    startSeq('0);
    applyStimulus(20);
    checkRises("t2", 11, 12, 13, 14);

    // Soft request pulsed at edge 16 restarts mid-sequence
    startSeq({16'd2, 16'd5, 16'd3, 16'd0});
    applyStimulus(15);
    bus_if.rst_req_i = 1'b1;
    applyStimulus(1);
    bus_if.rst_req_i = 1'b0;
    checkOutput("t3_rstn_after_req", 32'(bus_if.rstn_o), 32'h0);
    clearRises();
    applyStimulus(30);
    checkRises("t3", 27, 31, 37, 40);

    // Delay changes after capture are ignored until the next restart
    startSeq({16'd2, 16'd5, 16'd3, 16'd0});
    applyStimulus(12);
    bus_if.dly_i = {4{16'd7}};
    applyStimulus(15);
    checkRises("t4a", 11, 15, 21, 24);
    bus_if.rst_req_i = 1'b1;
    applyStimulus(1);
    bus_if.rst_req_i = 1'b0;
    edge_n = 0;
    clearRises();
    applyStimulus(45);
    checkRises("t4b", 18, 26, 34, 42);

    // Randomized delays, restarts, resets and delay changes
    for (int r = 0; r < 25; r++) begin
      for (int k = 0; k < N; k++) d[k*DW +: DW] = DW'($urandom_range(0, 12));
      startSeq(d);
      for (int c = 0; c < 90; c++) begin
        bus_if.rst_req_i = ($urandom_range(0, 99) < 3);
        sys_rst_i        = ($urandom_range(0, 99) < 1);
        if ($urandom_range(0, 9) == 0)
          for (int k = 0; k < N; k++) bus_if.dly_i[k*DW +: DW] = DW'($urandom_range(0, 12));
        applyStimulus(1);
      end
      bus_if.rst_req_i = 1'b0;
      sys_rst_i        = 1'b0;
    end

    // Maximum delay on stage 0: no wrap, no early release
    startSeq({16'd0, 16'd0, 16'd0, 16'hFFFF});
    applyStimulus(HOLD + 65536 + 6);
    checkRises("t6", HOLD + 65536, HOLD + 65537, HOLD + 65538, HOLD + 65539);

    $display("Result: errors=%0d of %0d checks", err_count, check_count);
    $finish;
  end

endmodule
